// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner: cleans the two raw vehicle-detector inputs.
// Each lane runs a synchronizer, a consecutive-cycle debouncer, a presence
// hold stretcher and a saturating arrival counter. The lanes are identical
// and share no state, so one lane module is instantiated twice.

module traffic_sensor_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_i,
    output logic             req_o,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1) + 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HLOAD = HW'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             rise_s;

    // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (sync2_q == deb_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DLAST) begin
            deb_d  = sync2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    // Hold stretcher: reload while present, count down once the level drops.
    always_comb begin
        hcnt_d = hcnt_q;
        if (deb_q) begin
            hcnt_d = HLOAD;
        end else if (hcnt_q != '0) begin
            hcnt_d = hcnt_q - HW'(1);
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // Arrival counter: one count per debounced rising edge, saturating at all-ones.
    always_comb begin
        rise_s = deb_d & ~deb_q;
        cnt_d  = cnt_q;
        if (rise_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Request level is computed from next state so the registered output
    // equals deb | (hcnt != 0) of the current cycle with no extra latency.
    always_comb begin
        req_d = deb_d | (hcnt_d != '0);
    end

    // State registers; reset clears everything so nothing pending survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    assign req_o = req_q;
    assign cnt_o = cnt_q;
endmodule

module traffic_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_a,
    input  logic             raw_b,
    output logic             sa,
    output logic             sb,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    traffic_sensor_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .CNT_W          (CNT_W)
    ) u_lane_a (
        .clk   (clk),
        .reset (reset),
        .raw_i (raw_a),
        .req_o (sa),
        .cnt_o (cnt_a)
    );

    traffic_sensor_lane #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .CNT_W          (CNT_W)
    ) u_lane_b (
        .clk   (clk),
        .reset (reset),
        .raw_i (raw_b),
        .req_o (sb),
        .cnt_o (cnt_b)
    );
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner (defaults, 10 ns clock).
// Stimulus pushes expected output-change events (cycle + values) into a
// queue; a monitor pops one entry each time the outputs change.
// Inputs are driven on the falling edge; if a level is driven at the falling
// edge where cyc == t, a rise is visible at cyc t+6, a deb fall at
// t+6 and the end of the hold at t+14.

module tb_traffic_sensor_conditioner;
    logic       clk = 1'b0;
    logic       reset;
    logic       raw_a, raw_b;
    logic       sa, sb;
    logic [7:0] cnt_a, cnt_b;

    typedef struct {
        int          cyc;
        logic [17:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        mon_en;
    logic [17:0] prev_obs;

    traffic_sensor_conditioner dut (
        .clk   (clk),
        .reset (reset),
        .raw_a (raw_a),
        .raw_b (raw_b),
        .sa    (sa),
        .sb    (sb),
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_ev(input int c, input logic s_a, input logic s_b,
                          input int ca, input int cb);
        exp_t e;
        e.cyc = c;
        e.val = {s_a, s_b, 8'(ca), 8'(cb)};
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every output change must match the next queued event.
    always @(negedge clk) begin
        logic [17:0] obs;
        exp_t        e;
        #1;
        if (mon_en) begin
            obs = {sa, sb, cnt_a, cnt_b};
            if (obs !== prev_obs) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%h", cyc, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val !== obs) begin
                        bad++;
                        $display("FAIL event cyc=%0d got=%h expected cyc=%0d val=%h",
                                 cyc, obs, e.cyc, e.val);
                    end
                end
                prev_obs = obs;
            end
        end
    end

    initial begin
        int t;
        reset    = 1'b0;
        raw_a    = 1'b0;
        raw_b    = 1'b0;
        mon_en   = 1'b0;
        prev_obs = 18'd0;

        wait_n(3);
        #1 check("reset_state", {sa, sb, cnt_a, cnt_b}, 18'd0);
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        wait_n(3);

        // 3-cycle pulse is filtered: no events expected
        raw_a = 1'b1; wait_n(3); raw_a = 1'b0; wait_n(20);

        // 4-cycle pulse: rise after E5, fall after hold
        t = cyc;
        exp_ev(t + 6, 1'b1, 1'b0, 1, 0);
        exp_ev(t + 18, 1'b0, 1'b0, 1, 0);
        raw_a = 1'b1; wait_n(4); raw_a = 1'b0; wait_n(25);

        // 20-cycle level: sa high until E13 after the fall
        t = cyc;
        exp_ev(t + 6, 1'b1, 1'b0, 2, 0);
        exp_ev(t + 34, 1'b0, 1'b0, 2, 0);
        raw_a = 1'b1; wait_n(20); raw_a = 1'b0; wait_n(40);

        // Bounce 1,1,0,1,1,1,... : count restarts at the 0
        t = cyc;
        exp_ev(t + 9, 1'b1, 1'b0, 3, 0);
        raw_a = 1'b1; wait_n(2); raw_a = 1'b0; wait_n(1); raw_a = 1'b1; wait_n(12);

        // Mid-cycle reset while sa=1, cnt_a=3
        check("pre_reset", {sa, sb, cnt_a, cnt_b}, {1'b1, 1'b0, 8'd3, 8'd0});
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        raw_a = 1'b0;
        #1 check("async_reset", {sa, sb, cnt_a, cnt_b}, 18'd0);
        @(negedge clk);
        reset    = 1'b1;
        prev_obs = 18'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1 check("post_reset_quiet", {sa, sb, cnt_a, cnt_b}, 18'd0);
        end
        @(negedge clk);
        mon_en = 1'b1;
        wait_n(2);

        // Re-arrival during hold: sa stays high, count increments
        t = cyc;
        exp_ev(t + 6, 1'b1, 1'b0, 1, 0);
        exp_ev(t + 22, 1'b1, 1'b0, 2, 0);
        exp_ev(t + 40, 1'b0, 1'b0, 2, 0);
        raw_a = 1'b1; wait_n(10); raw_a = 1'b0; wait_n(6);
        raw_a = 1'b1; wait_n(10); raw_a = 1'b0; wait_n(30);

        // Independence: a 5 cycles, b 3 cycles (filtered)
        t = cyc;
        exp_ev(t + 6, 1'b1, 1'b0, 3, 0);
        exp_ev(t + 19, 1'b0, 1'b0, 3, 0);
        raw_a = 1'b1; raw_b = 1'b1; wait_n(3);
        raw_b = 1'b0; wait_n(2);
        raw_a = 1'b0; wait_n(25);

        // Independence: a 2 cycles (filtered), b 6 cycles
        t = cyc;
        exp_ev(t + 6, 1'b0, 1'b1, 3, 1);
        exp_ev(t + 20, 1'b0, 1'b0, 3, 1);
        raw_a = 1'b1; raw_b = 1'b1; wait_n(2);
        raw_a = 1'b0; wait_n(4);
        raw_b = 1'b0; wait_n(25);

        // Both rise together, different fall times
        t = cyc;
        exp_ev(t + 6, 1'b1, 1'b1, 4, 2);
        exp_ev(t + 18, 1'b0, 1'b1, 4, 2);
        exp_ev(t + 26, 1'b0, 1'b0, 4, 2);
        raw_a = 1'b1; raw_b = 1'b1; wait_n(4);
        raw_a = 1'b0; wait_n(8);
        raw_b = 1'b0; wait_n(30);

        // Saturation: 300 arrivals on lane B, sb held high by the hold window
        t = cyc;
        for (int k = 0; k < 300; k++) begin
            if (3 + k <= 255) exp_ev(t + 6 + 8 * k, 1'b0, 1'b1, 4, 3 + k);
        end
        exp_ev(t + 8 * 299 + 18, 1'b0, 1'b0, 4, 255);
        for (int k = 0; k < 300; k++) begin
            raw_b = 1'b1; wait_n(4);
            raw_b = 1'b0; wait_n(4);
        end
        wait_n(30);

        #1;
        check("final_counts", {sa, sb, cnt_a, cnt_b}, {1'b0, 1'b0, 8'd4, 8'd255});
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got=%0d pending expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
